// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the FIFO bank and its channels.
package fifo_pkg;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width: at least one bit, even for degenerate depths.
  function automatic int fifo_ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Low bit of element idx in a packed bus of w-bit elements.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fifo_channel.sv
// One FIFO channel: arbitrary depth storage, head/tail/count, flags, clear.
module fifo_channel
  import fifo_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int depth_p          = 4,
  parameter int almost_full_lo_p = depth_p - 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               clear_i,
  input  logic                               valid_i,
  input  logic [width_p-1:0]                 data_i,
  output logic                               ready_o,
  output logic                               valid_o,
  output logic [width_p-1:0]                 data_o,
  input  logic                               yumi_i,
  output logic [fifo_cnt_width(depth_p)-1:0] count_o,
  output logic                               almost_full_o
);

  localparam int cnt_w = fifo_cnt_width(depth_p);
  localparam int ptr_w = fifo_ptr_width(depth_p);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth_p - 1);
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth_p);
  localparam logic [cnt_w-1:0] af_cnt   = cnt_w'(almost_full_lo_p);

  logic [width_p-1:0] mem [depth_p];
  logic [ptr_w-1:0]   head, tail;
  logic [cnt_w-1:0]   count;
  logic               push, pop;

  // Modulo-depth increment; works for non-power-of-two depths.
  function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_w'(1);
  endfunction

  // Flags come only from registered count, so ready has no path from yumi.
  assign ready_o       = (count != full_cnt);
  assign valid_o       = (count != '0);
  assign almost_full_o = (count >= af_cnt);
  assign count_o       = count;
  assign push          = valid_i & ready_o;
  assign pop           = yumi_i & valid_o;
  assign data_o        = valid_o ? mem[head] : '0;

  // Pointer and count update; reset beats clear, clear beats traffic.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= bump(tail);
      if (pop)  head <= bump(head);
      if (push && !pop)      count <= count + cnt_w'(1);
      else if (pop && !push) count <= count - cnt_w'(1);
    end
  end

  // Storage write; no reset needed since data_o is masked when empty.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i && !clear_i) mem[tail] <= data_i;
  end

  // Popping an empty channel is a sequencer bug; the pop itself is ignored.
  always_ff @(posedge clk_i) begin
    if (!reset_i) illegal_pop: assert (!yumi_i || valid_o);
  end

endmodule

// File: rtl/fifo_bank.sv
// Bank of independent FIFO channels feeding the systolic array edge.
module fifo_bank
  import fifo_pkg::*;
#(
  parameter int width_p          = 8,
  parameter int depth_p          = 4,
  parameter int channels_p       = 4,
  parameter int almost_full_lo_p = depth_p - 1
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic [channels_p-1:0]                         clear_i,
  input  logic [channels_p-1:0]                         valid_i,
  input  logic [channels_p*width_p-1:0]                 data_i,
  output logic [channels_p-1:0]                         ready_o,
  output logic [channels_p-1:0]                         valid_o,
  output logic [channels_p*width_p-1:0]                 data_o,
  input  logic [channels_p-1:0]                         yumi_i,
  output logic [channels_p*fifo_cnt_width(depth_p)-1:0] count_o,
  output logic [channels_p-1:0]                         almost_full_o,
  output logic                                          all_valid_o
);

  localparam int cnt_w = fifo_cnt_width(depth_p);

  // One self-contained channel per lane; no shared state between them.
  for (genvar c = 0; c < channels_p; c++) begin : g_ch
    fifo_channel #(
      .width_p         (width_p),
      .depth_p         (depth_p),
      .almost_full_lo_p(almost_full_lo_p)
    ) u_ch (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .clear_i      (clear_i[c]),
      .valid_i      (valid_i[c]),
      .data_i       (data_i[slice_lo(c, width_p) +: width_p]),
      .ready_o      (ready_o[c]),
      .valid_o      (valid_o[c]),
      .data_o       (data_o[slice_lo(c, width_p) +: width_p]),
      .yumi_i       (yumi_i[c]),
      .count_o      (count_o[slice_lo(c, cnt_w) +: cnt_w]),
      .almost_full_o(almost_full_o[c])
    );
  end

  // Wavefront-aligned pop hint for the sequencer; lockstep is not enforced here.
  assign all_valid_o = &valid_o;

endmodule
